// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: interlock and flush sequencer for the 5-stage 8-bit pipeline.
// A 3-slot shadow pipeline (EX, MEM, WB) records the register and flag writes
// of every instruction in flight past ID. Because there is no forwarding,
// read-after-write hazards are resolved by stalling, and a taken branch in EX
// squashes the two younger instructions.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W = 3,
    parameter bit WB_BYPASS  = 1'b0,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src_a,
    input  logic [REG_ADDR_W-1:0] id_src_b,
    input  logic                  id_use_a,
    input  logic                  id_use_b,
    input  logic [REG_ADDR_W-1:0] id_dst,
    input  logic                  id_reg_write,
    input  logic                  id_read_c,
    input  logic                  id_read_z,
    input  logic                  id_write_c,
    input  logic                  id_write_z,
    input  logic                  ex_branch_taken,
    output logic                  pc_hold,
    output logic                  if_id_hold,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic [CNT_W-1:0]      stall_count
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dst;
        logic                  reg_write;
        logic                  write_c;
        logic                  write_z;
    } slot_t;

    // Index 0 = EX, 1 = MEM, 2 = WB. The WB slot is not active when the
    // register file writes before it reads.
    localparam logic [2:0] SLOT_ACTIVE = {(WB_BYPASS ? 1'b0 : 1'b1), 2'b11};

    slot_t ex_q, ex_d;
    slot_t mem_q, mem_d;
    slot_t wb_q, wb_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    slot_t slots [3];
    logic  hit_a, hit_b, hit_c, hit_z;
    logic  reg_hazard, flag_hazard;
    logic  stall, flush;

    // Scan the active shadow slots for writers of what the ID instruction reads.
    always_comb begin
        slots[0] = ex_q;
        slots[1] = mem_q;
        slots[2] = wb_q;
        hit_a    = 1'b0;
        hit_b    = 1'b0;
        hit_c    = 1'b0;
        hit_z    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (SLOT_ACTIVE[i]) begin
                if (slots[i].valid && slots[i].reg_write && (slots[i].dst == id_src_a)) begin
                    hit_a = 1'b1;
                end
                if (slots[i].valid && slots[i].reg_write && (slots[i].dst == id_src_b)) begin
                    hit_b = 1'b1;
                end
                if (slots[i].write_c) begin
                    hit_c = 1'b1;
                end
                if (slots[i].write_z) begin
                    hit_z = 1'b1;
                end
            end
        end
        reg_hazard  = id_valid && ((id_use_a && hit_a) || (id_use_b && hit_b));
        flag_hazard = id_valid && ((id_read_c && hit_c) || (id_read_z && hit_z));
        // A taken branch squashes the ID instruction, so its hazard is moot.
        stall       = (reg_hazard || flag_hazard) && !ex_branch_taken;
        flush       = ex_branch_taken;
    end

    // Pipeline controls; while in reset the pipe is held flushed and bubbled.
    always_comb begin
        pc_hold      = reset ? 1'b0 : stall;
        if_id_hold   = reset ? 1'b0 : stall;
        if_id_flush  = reset ? 1'b1 : flush;
        id_ex_bubble = reset ? 1'b1 : (stall || flush);
        stall_count  = stall_count_q;
    end

    // Next-state: the shadow pipe always advances; EX takes a bubble on stall/flush.
    always_comb begin
        mem_d = ex_q;
        wb_d  = mem_q;
        if (stall || flush) begin
            ex_d = '0;
        end else begin
            ex_d = '{valid:     id_valid,
                     dst:       id_dst,
                     reg_write: id_reg_write,
                     write_c:   id_write_c,
                     write_z:   id_write_z};
        end
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q          <= '0;
            mem_q         <= '0;
            wb_q          <= '0;
            stall_count_q <= '0;
        end else begin
            ex_q          <= ex_d;
            mem_q         <= mem_d;
            wb_q          <= wb_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Interlock and flush sequencer for the 5-stage 8-bit pipeline (IF, ID, EX, MEM, WB). It tracks the destination register and flag writes of every instruction in flight past ID in a 3-slot shadow pipeline. From that state it generates hold, flush and bubble controls for the PC, IF_ID and ID_EX registers. There is no forwarding network: read-after-write hazards on registers or on the C/Z flags are resolved by stalling, and a taken branch resolved in EX squashes the two younger instructions.

## Interface

Parameters:
- REG_ADDR_W, 3, register-file address width (8 registers)
- WB_BYPASS, 0, 1 = register file and flags are write-before-read, so the WB slot causes no hazard
- CNT_W, 16, width of the stall performance counter

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  IF_ID holds a real instruction; 0 = bubble
- id_src_a, id_src_b  in  REG_ADDR_W  source register addresses decoded in ID
- id_use_a, id_use_b  in  1  the instruction actually reads src A / src B
- id_dst  in  REG_ADDR_W  destination register of the ID instruction
- id_reg_write  in  1  the ID instruction writes id_dst
- id_read_c, id_read_z  in  1  the ID instruction reads C / Z (alu_use_carry, select_c, select_z)
- id_write_c, id_write_z  in  1  the ID instruction writes C / Z
- ex_branch_taken  in  1  the branch currently in EX is taken this cycle
- pc_hold  out  1  PC keeps its value
- if_id_hold  out  1  IF_ID keeps its contents
- if_id_flush  out  1  IF_ID loads a NOP
- id_ex_bubble  out  1  ID_EX loads all-zero control bits
- stall_count  out  CNT_W  saturating count of stall cycles

## Operation

- Shadow slots EX, MEM, WB each hold {valid, dst, reg_write, write_c, write_z}.
- Every cycle, unconditionally: WB <= MEM and MEM <= EX.
- EX slot load:
  - If stall or flush is asserted, EX <= bubble (all fields 0).
  - Otherwise EX <= {id_valid, id_dst, id_reg_write, id_write_c, id_write_z}.
- Active slots: EX and MEM; WB is also active when WB_BYPASS=0.
- Register hazard: id_valid AND ((id_use_a AND src_a matches) OR (id_use_b AND src_b matches)). A match means some active slot has valid AND reg_write AND dst equal to that source address.
- Flag hazard: id_valid AND ((id_read_c AND some active slot has write_c) OR (id_read_z AND some active slot has write_z)).
- stall = (register hazard OR flag hazard) AND NOT ex_branch_taken.
- flush = ex_branch_taken.
- Output equations, all combinational from slot state and inputs:
  - pc_hold = if_id_hold = stall.
  - if_id_flush = flush.
  - id_ex_bubble = stall OR flush.
- Priority: a flush overrides a stall. The squashed ID instruction can no longer hazard, and the PC must load the branch target.
- stall_count increments by 1 on every cycle with stall=1. It saturates at all-ones; there is no wrap.

## Timing

- Reset, while asserted:
  - All slots cleared to bubble.
  - stall_count <= 0.
  - Outputs forced to pc_hold=0, if_id_hold=0, if_id_flush=1, id_ex_bubble=1.
- First cycle after reset deassertion: all outputs are 0 unless the inputs create a hazard.
- Stall length for a dependent instruction directly behind its producer:
  - 3 cycles with WB_BYPASS=0.
  - 2 cycles with WB_BYPASS=1.
- With one independent instruction between producer and consumer, each figure drops by 1.
- The stall is released in the cycle the producer leaves the last active slot. The consumer then advances on the next edge.
- Flush latency: ex_branch_taken in cycle N makes if_id_flush and id_ex_bubble high in cycle N. After edge N, the EX slot is a bubble and IF_ID holds a NOP. Flush is one cycle per branch and has no internal state.
- Reset asserted mid-stall takes effect at the next edge: slots clear and the stall drops in the following cycle.
- Register 0 is not special-cased; the instruction decoder must deassert id_reg_write for writes to it.

## Test plan

- Back-to-back dependency, WB_BYPASS=0: EX slot writes r3, then ID instruction reads r3 on src_a. Required: stall high for exactly 3 cycles, 3 bubbles enter the EX slot, stall_count = 3.
- Same sequence with WB_BYPASS=1. Required: stall for exactly 2 cycles, stall_count = 2.
- Flag hazard: producer with write_c=1, consumer with id_read_c=1, no register overlap. Required: 3-cycle stall. The same pair with id_read_z=1 instead produces no stall.
- Branch during stall: a register hazard is active and ex_branch_taken pulses for 1 cycle. Required in that cycle: stall=0, pc_hold=0, if_id_flush=1, id_ex_bubble=1. stall_count is unchanged.
- Non-hazards: the same address on src_a with id_use_a=0, an in-flight producer with reg_write=0, and id_valid=0. Required: no stall in any case.
- Saturation and reset:
  - With CNT_W=4, hold a permanent hazard for 20 cycles. Required: stall_count stops at 15.
  - Assert reset for 1 cycle. Required: stall_count = 0, slots empty, outputs return to all 0.
